control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous reset, active-low (asserted at 0).
REQ-003 SHALL have port opCode, input, 6 bits: instruction opcode from the instruction register.
REQ-004 SHALL have ports PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst, output, 1 bit each: datapath controls.
REQ-005 SHALL have ports PCSource, ALUOp, ALUSrcB, output, 2 bits each: datapath controls.
REQ-006 SHALL have port state, output, 4 bits: current FSM state code, for debug.
REQ-007 SHALL have port illegal, output, 1 bit: one-cycle pulse in DECODE when opCode is unsupported.

Function
REQ-008 SHALL be a Moore FSM with these states and codes: FETCH0=0, FETCH1=1, DECODE=2, MEMADR=3, MEMRD=4, MEMWB=5, MEMWR=6, EXEC=7, ALUWB=8, BRANCH=9, JUMP=10, ADDIEX=11, ADDIWB=12; codes 13-15 SHALL go to FETCH0.
REQ-009 SHALL drive every output to 0 in each state unless this list sets it otherwise.
REQ-010 FETCH0: MemRead=1, IorD=0 (synchronous RAM address cycle); next state FETCH1.
REQ-011 FETCH1: MemRead=1, IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00, PCWrite=1 (PC<=PC+1); next state DECODE.
REQ-012 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target latched into the ALU output register). Next state by opCode: 000000 -> EXEC; 100011 or 101011 -> MEMADR; 000100 -> BRANCH; 000010 -> JUMP; 001000 -> ADDIEX; any other -> FETCH0 with illegal=1.
REQ-013 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00, IorD=1. Next state: MEMRD for 100011; MEMWR for 101011.
REQ-014 MEMRD: the MEMADR ALU/IorD controls held, MemRead=1; next state MEMWB.
REQ-015 MEMWB: RegDst=0, MemtoReg=1, RegWrite=1; next state FETCH0.
REQ-016 MEMWR: ALUSrcA=1, ALUSrcB=10, ALUOp=00, IorD=1, MemWrite=1; next state FETCH0.
REQ-017 EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10; next state ALUWB.
REQ-018 ALUWB: EXEC ALU controls held (writeback uses the unregistered ALU result), RegDst=1, MemtoReg=0, RegWrite=1; next state FETCH0.
REQ-019 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01; next state FETCH0.
REQ-020 JUMP: PCWrite=1, PCSource=10; next state FETCH0.
REQ-021 ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00; next state ADDIWB.
REQ-022 ADDIWB: ADDIEX ALU controls held, RegDst=0, MemtoReg=0, RegWrite=1; next state FETCH0.
REQ-023 opCode SHALL be sampled only in DECODE and MEMADR; changes in other states SHALL have no effect.
REQ-024 Instruction latency (cycles from FETCH0 to the next FETCH0): lw 6, sw 5, R-type 5, addi 5, beq 4, j 4, illegal 3.
REQ-025 Outputs SHALL be decoded from the state register only, with no combinational path from opCode except illegal.

Reset
REQ-026 reset=0 SHALL force state to FETCH0 immediately, independent of clk, including mid-instruction.
REQ-027 During reset, outputs SHALL be the FETCH0 values; illegal=0.
REQ-028 On the first rising clk edge after reset is released, the FSM SHALL advance from FETCH0 to FETCH1.

Configuration
REQ-029 Macro CONTROL_UNIT_ADDI_EN defined: opCode 001000 SHALL use the ADDIEX and ADDIWB path.
REQ-030 Macro CONTROL_UNIT_ADDI_EN undefined: ADDIEX and ADDIWB SHALL not exist, and opCode 001000 SHALL be illegal (DECODE -> FETCH0, illegal=1).

Verification
REQ-031 Release reset, opCode=100011 -> state sequence 0,1,2,3,4,5,0; RegWrite=1 and MemtoReg=1 only in state 5.
REQ-032 opCode=101011 -> states 0,1,2,3,6,0; MemWrite=1 only in state 6 with IorD=1.
REQ-033 opCode=000000 -> states 0,1,2,7,8,0; ALUOp=10 in states 7-8; RegDst=1 with RegWrite=1 in state 8.
REQ-034 opCode=000100 -> PCWriteCond=1, PCSource=01, ALUOp=01 in state 9; opCode=000010 -> PCWrite=1, PCSource=10 in state 10.
REQ-035 opCode=111111 -> illegal=1 for exactly one cycle in state 2; next state 0; no RegWrite, MemWrite or PCWrite asserted after FETCH1.
REQ-036 reset=0 asserted asynchronously in state 4 -> state=0 before the next clk edge; all write enables 0.

Source files
------------

// File: rtl/control_unit.sv
// control_unit: Moore FSM sequencing a multi-cycle MIPS-style datapath.
// Latency: lw 6, sw/R-type/addi 5, beq/j 4, illegal 3 cycles FETCH0->FETCH0; outputs registered-state decoded.
// Backpressure: none; the FSM advances every clk edge and never stalls.
//
// Ports:
//   clk, reset (async, active-low)   -- clock and reset
//   opCode[5:0]                      -- opcode from the instruction register, looked at in DECODE/MEMADR only
//   PCWriteCond..RegDst              -- 1-bit datapath enables/selects
//   PCSource, ALUOp, ALUSrcB [1:0]   -- 2-bit datapath selects
//   state[3:0]                       -- current state code (debug)
//   illegal                          -- one-cycle pulse in DECODE on an unsupported opcode
//
// Build option: define CONTROL_UNIT_ADDI_EN to add the ADDIEX/ADDIWB path for
// addi (opcode 001000). Without it, addi decodes as illegal.

module control_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opCode,
  output logic       PCWriteCond,
  output logic       PCWrite,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       MemtoReg,
  output logic       IRWrite,
  output logic       ALUSrcA,
  output logic       RegWrite,
  output logic       RegDst,
  output logic [1:0] PCSource,
  output logic [1:0] ALUOp,
  output logic [1:0] ALUSrcB,
  output logic [3:0] state,
  output logic       illegal
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef CONTROL_UNIT_ADDI_EN
  localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif

  typedef enum logic [3:0] {
    S_FETCH0 = 4'd0,
    S_FETCH1 = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_JUMP   = 4'd10
`ifdef CONTROL_UNIT_ADDI_EN
    ,
    S_ADDIEX = 4'd11,
    S_ADDIWB = 4'd12
`endif
  } state_t;

  state_t r_state;
  state_t w_next;

  // State register: reset drops straight to FETCH0 without waiting for clk.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_FETCH0;
    end else begin
      r_state <= w_next;
    end
  end

  assign state = r_state;

  // Next state and Moore outputs. illegal is the only output that looks at
  // opCode directly; everything else is a function of r_state alone.
  always_comb begin
    w_next      = S_FETCH0;
    PCWriteCond = 1'b0;
    PCWrite     = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    ALUSrcA     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    PCSource    = 2'b00;
    ALUOp       = 2'b00;
    ALUSrcB     = 2'b00;
    illegal     = 1'b0;

    case (r_state)
      // Synchronous RAM needs an address cycle before data appears.
      S_FETCH0: begin
        MemRead = 1'b1;
        w_next  = S_FETCH1;
      end
      S_FETCH1: begin
        MemRead = 1'b1;
        IRWrite = 1'b1;
        ALUSrcB = 2'b01;
        PCWrite = 1'b1;
        w_next  = S_DECODE;
      end
      // ALU computes the branch target speculatively while decoding.
      S_DECODE: begin
        ALUSrcB = 2'b11;
        case (opCode)
          OP_RTYPE:      w_next = S_EXEC;
          OP_LW, OP_SW:  w_next = S_MEMADR;
          OP_BEQ:        w_next = S_BRANCH;
          OP_J:          w_next = S_JUMP;
`ifdef CONTROL_UNIT_ADDI_EN
          OP_ADDI:       w_next = S_ADDIEX;
`endif
          default: begin
            w_next  = S_FETCH0;
            illegal = 1'b1;
          end
        endcase
      end
      // opCode is re-read here to split lw from sw; anything else aborts.
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        IorD    = 1'b1;
        if (opCode == OP_LW) begin
          w_next = S_MEMRD;
        end else if (opCode == OP_SW) begin
          w_next = S_MEMWR;
        end else begin
          w_next = S_FETCH0;
        end
      end
      // Address path held so the synchronous RAM sees a stable address.
      S_MEMRD: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        IorD    = 1'b1;
        MemRead = 1'b1;
        w_next  = S_MEMWB;
      end
      S_MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
        w_next   = S_FETCH0;
      end
      S_MEMWR: begin
        ALUSrcA  = 1'b1;
        ALUSrcB  = 2'b10;
        IorD     = 1'b1;
        MemWrite = 1'b1;
        w_next   = S_FETCH0;
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
        w_next  = S_ALUWB;
      end
      // Writeback takes the live ALU result, so ALU controls stay put.
      S_ALUWB: begin
        ALUSrcA  = 1'b1;
        ALUOp    = 2'b10;
        RegDst   = 1'b1;
        RegWrite = 1'b1;
        w_next   = S_FETCH0;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        w_next      = S_FETCH0;
      end
      S_JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
        w_next   = S_FETCH0;
      end
`ifdef CONTROL_UNIT_ADDI_EN
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        w_next  = S_ADDIWB;
      end
      S_ADDIWB: begin
        ALUSrcA  = 1'b1;
        ALUSrcB  = 2'b10;
        RegWrite = 1'b1;
        w_next   = S_FETCH0;
      end
`endif
      // Unused codes drive all-zero controls and recover to FETCH0.
      default: begin
        w_next = S_FETCH0;
      end
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;

  logic       clk;
  logic       reset;
  logic [5:0] opCode;
  logic       PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg;
  logic       IRWrite, ALUSrcA, RegWrite, RegDst;
  logic [1:0] PCSource, ALUOp, ALUSrcB;
  logic [3:0] state;
  logic       illegal;

  int total = 0;
  int bad   = 0;
  int seq[$];

  control_unit dut (
    .clk         (clk),
    .reset       (reset),
    .opCode      (opCode),
    .PCWriteCond (PCWriteCond),
    .PCWrite     (PCWrite),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .MemtoReg    (MemtoReg),
    .IRWrite     (IRWrite),
    .ALUSrcA     (ALUSrcA),
    .RegWrite    (RegWrite),
    .RegDst      (RegDst),
    .PCSource    (PCSource),
    .ALUOp       (ALUOp),
    .ALUSrcB     (ALUSrcB),
    .state       (state),
    .illegal     (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed view of all control outputs:
  // {PCWriteCond,PCWrite,IorD,MemRead,MemWrite,MemtoReg,IRWrite,ALUSrcA,RegWrite,RegDst,PCSource,ALUOp,ALUSrcB}
  function automatic logic [15:0] ctrl_now();
    return {PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
            ALUSrcA, RegWrite, RegDst, PCSource, ALUOp, ALUSrcB};
  endfunction

  // Expected controls per state, written straight from the state table.
  function automatic logic [15:0] exp_ctrl(input int st);
    logic pcwc, pcw, iord, mrd, mwr, m2r, irw, srca, rw, rdst;
    logic [1:0] pcs, aop, srcb;
    {pcwc, pcw, iord, mrd, mwr, m2r, irw, srca, rw, rdst} = '0;
    pcs = 2'b00; aop = 2'b00; srcb = 2'b00;
    case (st)
      0:  mrd = 1;
      1:  begin mrd = 1; irw = 1; srcb = 2'b01; pcw = 1; end
      2:  srcb = 2'b11;
      3:  begin srca = 1; srcb = 2'b10; iord = 1; end
      4:  begin srca = 1; srcb = 2'b10; iord = 1; mrd = 1; end
      5:  begin m2r = 1; rw = 1; end
      6:  begin srca = 1; srcb = 2'b10; iord = 1; mwr = 1; end
      7:  begin srca = 1; aop = 2'b10; end
      8:  begin srca = 1; aop = 2'b10; rdst = 1; rw = 1; end
      9:  begin srca = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
      10: begin pcw = 1; pcs = 2'b10; end
      11: begin srca = 1; srcb = 2'b10; end
      12: begin srca = 1; srcb = 2'b10; rw = 1; end
      default: ;
    endcase
    return {pcwc, pcw, iord, mrd, mwr, m2r, irw, srca, rw, rdst, pcs, aop, srcb};
  endfunction

  function automatic bit addi_enabled();
`ifdef CONTROL_UNIT_ADDI_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit is_illegal(input logic [5:0] op);
    case (op)
      6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010: return 1'b0;
      6'b001000: return !addi_enabled();
      default:   return 1'b1;
    endcase
  endfunction

  // Reference: the state walk an instruction takes from FETCH0 until the
  // next FETCH0 (its length is the instruction latency).
  task automatic build_seq(input logic [5:0] op);
    seq = {0, 1, 2};
    case (op)
      6'b100011: seq = {seq, 3, 4, 5};
      6'b101011: seq = {seq, 3, 6};
      6'b000000: seq = {seq, 7, 8};
      6'b000100: seq.push_back(9);
      6'b000010: seq.push_back(10);
      6'b001000: if (addi_enabled()) seq = {seq, 11, 12};
      default: ;
    endcase
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int latency_of(input logic [5:0] op);
    case (op)
      6'b100011: return 6;
      6'b101011, 6'b000000: return 5;
      6'b001000: return addi_enabled() ? 5 : 3;
      6'b000100, 6'b000010: return 4;
      default: return 3;
    endcase
  endfunction

  // Drives one instruction and checks every cycle of it. opCode is held at
  // op only where it is sampled; elsewhere it is scrambled to prove it is
  // ignored. With stop_at >= 0, returns right after checking that state.
  task automatic run_instr(input logic [5:0] op, input int stop_at);
    build_seq(op);
    chk("latency", seq.size(), latency_of(op));
    foreach (seq[k]) begin
      if (seq[k] == 2 || seq[k] == 3) opCode = op;
      else                            opCode = 6'($urandom);
      #1;
      chk($sformatf("state op=%b k=%0d", op, k), state, seq[k]);
      chk($sformatf("ctrl op=%b st=%0d", op, seq[k]), ctrl_now(), exp_ctrl(seq[k]));
      chk($sformatf("illegal op=%b st=%0d", op, seq[k]), illegal,
          (seq[k] == 2) && is_illegal(op));
      if (seq[k] == stop_at) return;
      @(negedge clk);
    end
  endtask

  logic [5:0] legal_ops [6];

  initial begin
    legal_ops[0] = 6'b100011;
    legal_ops[1] = 6'b101011;
    legal_ops[2] = 6'b000000;
    legal_ops[3] = 6'b000100;
    legal_ops[4] = 6'b000010;
    legal_ops[5] = 6'b001000;

    // Reset held with an illegal opcode present: FETCH0 outputs, no illegal.
    reset  = 1'b0;
    opCode = 6'b111111;
    repeat (2) @(negedge clk);
    #1;
    chk("reset state", state, 0);
    chk("reset ctrl", ctrl_now(), exp_ctrl(0));
    chk("reset illegal", illegal, 0);
    @(negedge clk);
    reset = 1'b1;

    // Directed: each instruction class once.
    run_instr(6'b100011, -1);
    run_instr(6'b101011, -1);
    run_instr(6'b000000, -1);
    run_instr(6'b000100, -1);
    run_instr(6'b000010, -1);
    run_instr(6'b111111, -1);
    run_instr(6'b001000, -1);

    // Asynchronous reset in MEMRD, well before the next rising edge.
    run_instr(6'b100011, 4);
    #2;
    reset = 1'b0;
    #1;
    chk("async reset state", state, 0);
    chk("async reset ctrl", ctrl_now(), exp_ctrl(0));
    chk("async reset illegal", illegal, 0);
    @(negedge clk);
    chk("reset held over edge", state, 0);
    reset = 1'b1;

    // Randomized instruction stream.
    for (int n = 0; n < 60; n++) begin
      int pick;
      logic [5:0] op;
      pick = $urandom_range(0, 7);
      if (pick < 6)       op = legal_ops[pick];
      else if (pick == 6) op = 6'b111111;
      else                op = 6'($urandom);
      run_instr(op, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
